// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer.
//   mode_t      : pattern select encoding used on the mode input
//   DIR_UP/DOWN : bounce direction values (UP = toward MSB)
//   ctr_width() : prescaler counter width for a given PERIOD
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'd0,
    MODE_ROTR   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // A PERIOD of 1 still needs a 1-bit counter so the register is never
  // zero width.
  function automatic int ctr_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Prescaler for the LED sequencer.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the counter
//   en    : 1 = count, 0 = hold the counter
//   tick  : high during the cycle whose rising edge ends a PERIOD
module tick_gen
  import led_seq_pkg::*;
#(
  parameter int PERIOD = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int              CW   = ctr_width(PERIOD);
  localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

  logic [CW-1:0] ctr;

  // tick is decoded combinationally from the held count so the consumer
  // can update its pattern on the same edge that wraps the counter.
  assign tick = en && (ctr == LAST);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr <= '0;
    end else if (tick) begin
      ctr <= '0;
    end else if (en) begin
      ctr <= ctr + CW'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   en    : 1 = advance prescaler and pattern, 0 = freeze all state
//   mode  : pattern select (rotate-left, rotate-right, bounce, count),
//           sampled only at the end of each prescaler period
//   led   : registered pattern
//   step  : one-cycle pulse, high while a freshly updated led is shown
//   dir   : registered bounce direction (0 = toward MSB, 1 = toward LSB)
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NLED   = 6,
  parameter int PERIOD = 50000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      mode,
  output logic [NLED-1:0] led,
  output logic            step,
  output logic            dir
);

  logic            tick;
  mode_t           mode_q;
  mode_t           eff_mode;
  logic [NLED-1:0] led_nxt;
  logic            dir_nxt;

  tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick)
  );

  // The mode being latched on this edge drives the update immediately;
  // between ticks the next-state value is unused.
  assign eff_mode = tick ? mode_t'(mode) : mode_q;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    led_nxt = led;
    dir_nxt = dir;
    if (eff_mode == MODE_COUNT) begin
      led_nxt = led + NLED'(1);
    end else if (!$onehot(led)) begin
      // Shift patterns need exactly one lit LED; recover to a known start.
      led_nxt = NLED'(1);
      dir_nxt = DIR_UP;
    end else begin
      case (eff_mode)
        MODE_ROTL: led_nxt = {led[NLED-2:0], led[NLED-1]};
        MODE_ROTR: led_nxt = {led[0], led[NLED-1:1]};
        MODE_BOUNCE: begin
          // Reversal and the first shift back happen in one step, so an
          // end LED is never shown on two consecutive steps.
          if (dir == DIR_UP) begin
            if (led[NLED-1]) begin
              dir_nxt = DIR_DOWN;
              led_nxt = led >> 1;
            end else begin
              led_nxt = led << 1;
            end
          end else begin
            if (led[0]) begin
              dir_nxt = DIR_UP;
              led_nxt = led << 1;
            end else begin
              led_nxt = led >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led    <= NLED'(1);
      dir    <= DIR_UP;
      mode_q <= MODE_ROTL;
      step   <= 1'b0;
    end else begin
      step <= tick;
      if (tick) begin
        mode_q <= mode_t'(mode);
        led    <= led_nxt;
        dir    <= dir_nxt;
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed testbench for led_sequencer: NLED=6 with PERIOD=4 (dut) and
// PERIOD=1 (dut1).
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [1:0] mode;
  logic [5:0] led;
  logic       step, dir;

  logic       rst1_n, en1;
  logic [1:0] mode1;
  logic [5:0] led1;
  logic       step1, dir1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  led_sequencer #(.NLED(6), .PERIOD(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .mode (mode),
    .led  (led),
    .step (step),
    .dir  (dir)
  );

  led_sequencer #(.NLED(6), .PERIOD(1)) dut1 (
    .clk  (clk),
    .rst_n(rst1_n),
    .en   (en1),
    .mode (mode1),
    .led  (led1),
    .step (step1),
    .dir  (dir1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next step pulse; n = cycles consumed.
  task automatic wait_step(input string tag, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < 64);
    if (!step) check({tag, "_timeout"}, 32'(step), 32'd1);
  endtask

  task automatic do_reset(input string tag, input logic [1:0] m);
    rst_n = 1'b0;
    mode  = m;
    cyc();
    check({tag, "_rst_led"},  32'(led),  32'h01);
    check({tag, "_rst_step"}, 32'(step), 32'd0);
    check({tag, "_rst_dir"},  32'(dir),  32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    logic [5:0] bounce_led [12] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10,
                                    6'h08, 6'h04, 6'h02, 6'h01, 6'h02, 6'h04};
    logic       bounce_dir [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};

    rst_n = 1'b0; en = 1'b1; mode = 2'd0;
    rst1_n = 1'b0; en1 = 1'b1; mode1 = 2'd0;
    cyc();

    // Reset then rotate-left: first step after 4 enabled cycles.
    do_reset("a", 2'd0);
    for (int i = 0; i < 3; i++) cyc();
    check("a_hold_led", 32'(led), 32'h01);
    check("a_hold_step", 32'(step), 32'd0);
    cyc();
    check("a_first_led", 32'(led), 32'h02);
    check("a_first_step", 32'(step), 32'd1);
    cyc();
    check("a_step_pulse", 32'(step), 32'd0);
    for (int i = 0; i < 4; i++) wait_step("rotl", n);
    check("rotl_msb", 32'(led), 32'h20);
    wait_step("rotl", n);
    check("rotl_wrap", 32'(led), 32'h01);

    // Rotate-right wrap from bit 0 to the MSB.
    mode = 2'd1;
    wait_step("rotr", n);
    check("rotr_wrap", 32'(led), 32'h20);
    wait_step("rotr", n);
    check("rotr_next", 32'(led), 32'h10);

    // Bounce from reset, twelve steps.
    do_reset("b", 2'd2);
    for (int i = 0; i < 12; i++) begin
      wait_step($sformatf("bnc%0d", i + 1), n);
      check($sformatf("bnc%0d_led", i + 1), 32'(led), 32'(bounce_led[i]));
      check($sformatf("bnc%0d_dir", i + 1), 32'(dir), 32'(bounce_dir[i]));
    end

    // Reset pulse mid-bounce while travelling toward the LSB.
    do_reset("c", 2'd2);
    for (int i = 0; i < 7; i++) wait_step("c_bnc", n);
    check("c_dir_down", 32'(dir), 32'd1);
    cyc();
    do_reset("c_mid", 2'd2);
    wait_step("c_after", n);
    check("c_latency", 32'(n), 32'd4);
    check("c_led", 32'(led), 32'h02);

    // Count mode: dir held, mode switch mid-period deferred, reload.
    do_reset("d", 2'd2);
    for (int i = 0; i < 9; i++) wait_step("d_bnc", n);
    mode = 2'd3;
    for (int i = 0; i < 3; i++) wait_step("d_cnt", n);
    check("cnt_led5", 32'(led), 32'h05);
    check("cnt_dir_held", 32'(dir), 32'd1);
    cyc();
    mode = 2'd0;
    cyc();
    check("cnt_midswitch_led", 32'(led), 32'h05);
    check("cnt_midswitch_step", 32'(step), 32'd0);
    wait_step("d_reload", n);
    check("reload_latency", 32'(n), 32'd2);
    check("reload_led", 32'(led), 32'h01);
    check("reload_dir", 32'(dir), 32'd0);
    mode = 2'd3;
    for (int i = 0; i < 62; i++) wait_step("d_up", n);
    check("cnt_allones", 32'(led), 32'h3f);
    wait_step("d_wrap", n);
    check("cnt_wrap", 32'(led), 32'h00);
    mode = 2'd1;
    wait_step("d_zero", n);
    check("zero_reload", 32'(led), 32'h01);

    // Freeze with en low at ctr=2, then resume.
    do_reset("e", 2'd0);
    wait_step("e_first", n);
    cyc();
    cyc();
    en = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (step) seen++;
    end
    check("frz_steps", 32'(seen), 32'd0);
    check("frz_led", 32'(led), 32'h02);
    en = 1'b1;
    wait_step("e_resume", n);
    check("resume_latency", 32'(n), 32'd2);
    check("resume_led", 32'(led), 32'h04);

    // PERIOD=1: a step on every enabled cycle.
    check("p1_rst_led", 32'(led1), 32'h01);
    check("p1_rst_step", 32'(step1), 32'd0);
    rst1_n = 1'b1;
    cyc();
    check("p1_s1_step", 32'(step1), 32'd1);
    check("p1_s1_led", 32'(led1), 32'h02);
    cyc();
    check("p1_s2_step", 32'(step1), 32'd1);
    check("p1_s2_led", 32'(led1), 32'h04);
    en1 = 1'b0;
    cyc();
    check("p1_frz_step", 32'(step1), 32'd0);
    check("p1_frz_led", 32'(led1), 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
